// File: rtl/sfifo_wr_arb.sv
// sfifo_wr_arb: two-requester round-robin arbiter for one FIFO write port.
// A winner keeps the port for its whole burst (len+1 beats). Accepted beats
// go to the FIFO through one register stage. The FIFO almost-full flag
// blocks acceptance. Its 2-entry slack covers the one write still in flight.
module sfifo_wr_arb #(
  parameter int DW  = 32,
  parameter int BLW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           r0_req,
  input  logic [BLW-1:0] r0_len,
  input  logic           r0_valid,
  input  logic [DW-1:0]  r0_data,
  output logic           r0_ready,
  output logic           r0_done,
  input  logic           r1_req,
  input  logic [BLW-1:0] r1_len,
  input  logic           r1_valid,
  input  logic [DW-1:0]  r1_data,
  output logic           r1_ready,
  output logic           r1_done,
  output logic           fifo_wen,
  output logic [DW-1:0]  fifo_wdata,
  input  logic           fifo_wqfull,
  output logic [1:0]     grant,
  output logic           busy
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e         r_state;
  state_e         w_state_nx;
  logic [1:0]     r_grant;
  logic [1:0]     w_grant_nx;
  logic [BLW-1:0] r_cnt;
  logic [BLW-1:0] w_cnt_nx;
  logic           r_last;      // owner of the previous burst (1 = requester 1)
  logic           w_last_nx;
  logic           r_fifo_wen;
  logic [DW-1:0]  r_fifo_wdata;

  logic           w_ready0;
  logic           w_ready1;
  logic           w_acc0;
  logic           w_acc1;
  logic           w_acc;
  logic           w_cnt_zero;
  logic [DW-1:0]  w_owner_data;

  // Grant is zero outside BURST, so ready needs no state term.
  assign w_ready0     = r_grant[0] & ~fifo_wqfull;
  assign w_ready1     = r_grant[1] & ~fifo_wqfull;
  assign w_acc0       = r0_valid & w_ready0;
  assign w_acc1       = r1_valid & w_ready1;
  assign w_acc        = w_acc0 | w_acc1;
  assign w_cnt_zero   = (r_cnt == {BLW{1'b0}});
  assign w_owner_data = r_grant[1] ? r1_data : r0_data;

  assign r0_ready   = w_ready0;
  assign r1_ready   = w_ready1;
  assign r0_done    = w_acc0 & w_cnt_zero;
  assign r1_done    = w_acc1 & w_cnt_zero;
  assign fifo_wen   = r_fifo_wen;
  assign fifo_wdata = r_fifo_wdata;
  assign grant      = r_grant;
  assign busy       = (r_state == S_BURST);

  // Next-state logic: round-robin pick in IDLE, beat counting in BURST.
  always_comb begin
    w_state_nx = r_state;
    w_grant_nx = r_grant;
    w_cnt_nx   = r_cnt;
    w_last_nx  = r_last;
    case (r_state)
      S_IDLE: begin
        if (r0_req && r1_req) begin
          w_state_nx = S_BURST;
          if (r_last) begin
            w_grant_nx = 2'b01;
            w_cnt_nx   = r0_len;
          end else begin
            w_grant_nx = 2'b10;
            w_cnt_nx   = r1_len;
          end
        end else if (r0_req) begin
          w_state_nx = S_BURST;
          w_grant_nx = 2'b01;
          w_cnt_nx   = r0_len;
        end else if (r1_req) begin
          w_state_nx = S_BURST;
          w_grant_nx = 2'b10;
          w_cnt_nx   = r1_len;
        end else begin
          w_grant_nx = 2'b00;
        end
      end
      S_BURST: begin
        if (w_acc) begin
          if (w_cnt_zero) begin
            w_state_nx = S_IDLE;
            w_grant_nx = 2'b00;
            w_last_nx  = r_grant[1];
          end else begin
            w_cnt_nx = r_cnt - BLW'(1'b1);
          end
        end else begin
          w_cnt_nx = r_cnt;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_grant_nx = 2'b00;
        w_cnt_nx   = {BLW{1'b0}};
      end
    endcase
  end

  // Arbiter state register; reset makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= 2'b00;
      r_cnt   <= {BLW{1'b0}};
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nx;
      r_grant <= w_grant_nx;
      r_cnt   <= w_cnt_nx;
      r_last  <= w_last_nx;
    end
  end

  // FIFO write stage: one-cycle delayed copy of each accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fifo_wen   <= 1'b0;
      r_fifo_wdata <= {DW{1'b0}};
    end else begin
      r_fifo_wen <= w_acc;
      if (w_acc) begin
        r_fifo_wdata <= w_owner_data;
      end
    end
  end

endmodule

// File: tb/tb_sfifo_wr_arb.sv
// tb_sfifo_wr_arb: directed bench for sfifo_wr_arb with hand-computed
// expectations on grant, ready/done, and FIFO write traffic.
module tb_sfifo_wr_arb;
  localparam int DW  = 32;
  localparam int BLW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           r0_req, r0_valid, r0_ready, r0_done;
  logic [BLW-1:0] r0_len;
  logic [DW-1:0]  r0_data;
  logic           r1_req, r1_valid, r1_ready, r1_done;
  logic [BLW-1:0] r1_len;
  logic [DW-1:0]  r1_data;
  logic           fifo_wen, fifo_wqfull, busy;
  logic [DW-1:0]  fifo_wdata;
  logic [1:0]     grant;

  int n_checks = 0;
  int n_errors = 0;
  int wr_cnt   = 0;
  int wr_base;

  sfifo_wr_arb #(.DW(DW), .BLW(BLW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r0_len(r0_len), .r0_valid(r0_valid), .r0_data(r0_data),
    .r0_ready(r0_ready), .r0_done(r0_done),
    .r1_req(r1_req), .r1_len(r1_len), .r1_valid(r1_valid), .r1_data(r1_data),
    .r1_ready(r1_ready), .r1_done(r1_done),
    .fifo_wen(fifo_wen), .fifo_wdata(fifo_wdata), .fifo_wqfull(fifo_wqfull),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count FIFO writes mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (fifo_wen === 1'b1) wr_cnt <= wr_cnt + 1;
  end

  task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    r0_req = 1'b0; r0_len = '0; r0_valid = 1'b0; r0_data = '0;
    r1_req = 1'b0; r1_len = '0; r1_valid = 1'b0; r1_data = '0;
    fifo_wqfull = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One accepted beat from requester id; checks handshake, then the write.
  task automatic beat(input int id, input logic [DW-1:0] d, input logic exp_done, input string tag);
    if (id == 0) begin r0_valid = 1'b1; r0_data = d; end
    else         begin r1_valid = 1'b1; r1_data = d; end
    #1;
    chk_eq({tag, "_ready"}, (id == 0) ? r0_ready : r1_ready, 64'd1);
    chk_eq({tag, "_done"},  (id == 0) ? r0_done  : r1_done,  {63'd0, exp_done});
    chk_eq({tag, "_oth_ready"}, (id == 0) ? r1_ready : r0_ready, 64'd0);
    chk_eq({tag, "_oth_done"},  (id == 0) ? r1_done  : r0_done,  64'd0);
    tick();
    chk_eq({tag, "_wen"},   fifo_wen,   64'd1);
    chk_eq({tag, "_wdata"}, fifo_wdata, {32'd0, d});
    if (id == 0) r0_valid = 1'b0;
    else         r1_valid = 1'b0;
  endtask

  // One cycle with the owner's valid low: nothing written, burst continues.
  task automatic gap(input string tag);
    r0_valid = 1'b0;
    #1;
    chk_eq({tag, "_ready"}, r0_ready, 64'd1);
    chk_eq({tag, "_done"},  r0_done,  64'd0);
    chk_eq({tag, "_busy"},  busy,     64'd1);
    tick();
    chk_eq({tag, "_wen"},   fifo_wen, 64'd0);
  endtask

  initial begin
    apply_reset();
    rst_n = 1'b0;
    #1;
    chk_eq("rst_grant", grant, 64'd0);
    chk_eq("rst_busy",  busy,  64'd0);
    chk_eq("rst_wen",   fifo_wen, 64'd0);
    chk_eq("rst_wdata", fifo_wdata, 64'd0);
    chk_eq("rst_ready", {r1_ready, r0_ready}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Test 1: single burst of 4 beats from r0.
    r0_req = 1'b1; r0_len = 4'd3; r0_valid = 1'b1; r0_data = 32'hA0;
    #1;
    chk_eq("t1_idle_ready", r0_ready, 64'd0);
    tick();
    chk_eq("t1_grant", grant, 64'd1);
    chk_eq("t1_busy",  busy,  64'd1);
    wr_base = wr_cnt;
    for (int i = 0; i < 4; i++) beat(0, 32'hA0 + i, (i == 3), "t1_beat");
    r0_req = 1'b0;
    chk_eq("t1_grant_end", grant, 64'd0);
    chk_eq("t1_busy_end",  busy,  64'd0);
    tick();
    chk_eq("t1_wen_off", fifo_wen, 64'd0);
    chk_eq("t1_writes",  wr_cnt - wr_base, 64'd4);

    // Test 2: contention; r0 first, r1 next, then r0 again.
    apply_reset();
    tick();
    r0_req = 1'b1; r0_len = 4'd1;
    r1_req = 1'b1; r1_len = 4'd1;
    r1_valid = 1'b1; r1_data = 32'hDEADBEEF;
    #1;
    chk_eq("t2_idle_grant", grant, 64'd0);
    tick();
    chk_eq("t2_grant_r0", grant, 64'd1);
    wr_base = wr_cnt;
    beat(0, 32'hB0, 1'b0, "t2_r0a");
    beat(0, 32'hB1, 1'b1, "t2_r0a");
    r1_valid = 1'b0;
    chk_eq("t2_turn1", grant, 64'd0);
    chk_eq("t2_turn1_busy", busy, 64'd0);
    tick();
    chk_eq("t2_grant_r1", grant, 64'd2);
    beat(1, 32'hC0, 1'b0, "t2_r1");
    beat(1, 32'hC1, 1'b1, "t2_r1");
    r1_req = 1'b0;
    chk_eq("t2_turn2", grant, 64'd0);
    tick();
    chk_eq("t2_grant_r0b", grant, 64'd1);
    beat(0, 32'hB2, 1'b0, "t2_r0b");
    beat(0, 32'hB3, 1'b1, "t2_r0b");
    r0_req = 1'b0;
    tick();
    chk_eq("t2_writes", wr_cnt - wr_base, 64'd6);

    // Test 3: back-pressure mid-burst and on the last beat.
    r1_req = 1'b1; r1_len = 4'd7;
    tick();
    chk_eq("t3_grant", grant, 64'd2);
    wr_base = wr_cnt;
    for (int i = 0; i < 3; i++) beat(1, 32'hD0 + i, 1'b0, "t3_beat");
    fifo_wqfull = 1'b1; r1_valid = 1'b1; r1_data = 32'hD3;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk_eq("t3_stall_ready", r1_ready, 64'd0);
      chk_eq("t3_stall_done",  r1_done,  64'd0);
      tick();
      chk_eq("t3_stall_wen", fifo_wen, 64'd0);
    end
    fifo_wqfull = 1'b0;
    for (int i = 3; i < 7; i++) beat(1, 32'hD0 + i, 1'b0, "t3_beat");
    fifo_wqfull = 1'b1; r1_valid = 1'b1; r1_data = 32'hD7;
    #1;
    chk_eq("t3_last_ready", r1_ready, 64'd0);
    chk_eq("t3_last_done",  r1_done,  64'd0);
    tick();
    chk_eq("t3_last_wen",   fifo_wen, 64'd0);
    chk_eq("t3_last_grant", grant,    64'd2);
    fifo_wqfull = 1'b0;
    beat(1, 32'hD7, 1'b1, "t3_final");
    r1_req = 1'b0;
    chk_eq("t3_grant_end", grant, 64'd0);
    tick();
    chk_eq("t3_writes", wr_cnt - wr_base, 64'd8);

    // Test 4: valid gaps 1,0,1,0,1 on a 3-beat burst.
    r0_req = 1'b1; r0_len = 4'd2;
    tick();
    chk_eq("t4_grant", grant, 64'd1);
    wr_base = wr_cnt;
    beat(0, 32'hE0, 1'b0, "t4_beat");
    gap("t4_gap");
    beat(0, 32'hE1, 1'b0, "t4_beat");
    gap("t4_gap");
    beat(0, 32'hE2, 1'b1, "t4_beat");
    r0_req = 1'b0;
    chk_eq("t4_busy_end", busy, 64'd0);
    tick();
    chk_eq("t4_writes", wr_cnt - wr_base, 64'd3);

    // Test 5: maximum burst of 16 beats.
    r0_req = 1'b1; r0_len = 4'd15;
    tick();
    chk_eq("t5_grant", grant, 64'd1);
    wr_base = wr_cnt;
    for (int i = 0; i < 16; i++) beat(0, 32'h5000 + i, (i == 15), "t5_beat");
    r0_req = 1'b0;
    chk_eq("t5_grant_end", grant, 64'd0);
    tick();
    chk_eq("t5_writes", wr_cnt - wr_base, 64'd16);

    // Test 6: reset mid-burst; round-robin pointer returns to r0-first.
    r0_req = 1'b1; r0_len = 4'd4;
    tick();
    chk_eq("t6_grant", grant, 64'd1);
    beat(0, 32'hF0, 1'b0, "t6_beat");
    beat(0, 32'hF1, 1'b0, "t6_beat");
    r0_valid = 1'b1; r0_data = 32'hF2;
    rst_n = 1'b0;
    #1;
    chk_eq("t6_rst_grant", grant,    64'd0);
    chk_eq("t6_rst_busy",  busy,     64'd0);
    chk_eq("t6_rst_wen",   fifo_wen, 64'd0);
    chk_eq("t6_rst_ready", r0_ready, 64'd0);
    r0_valid = 1'b0; r0_len = 4'd0;
    r1_req = 1'b1;   r1_len = 4'd0;
    tick();
    rst_n = 1'b1;
    #1;
    chk_eq("t6_rel_grant", grant, 64'd0);
    tick();
    chk_eq("t6_rr_r0", grant, 64'd1);
    beat(0, 32'h60, 1'b1, "t6_r0");
    r0_req = 1'b0;
    chk_eq("t6_turn", grant, 64'd0);
    tick();
    chk_eq("t6_rr_r1", grant, 64'd2);
    beat(1, 32'h61, 1'b1, "t6_r1");
    r1_req = 1'b0;
    tick();
    chk_eq("t6_idle_grant", grant, 64'd0);
    chk_eq("t6_idle_busy",  busy,  64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sfifo_wr_arb.md
# sfifo_wr_arb

Two-requester, round-robin, burst-locked arbiter sharing the write port of one synchronous FIFO in the MIG-side datapath. Each requester asks for a burst of 1..2^BLW beats. The arbiter grants one requester for the whole burst and forwards accepted beats to the FIFO write port through a one-cycle register stage. It throttles on the FIFO's almost-full flag. The arbiter keeps no FIFO pointers of its own; occupancy is signalled only by `fifo_wqfull`.

## Interface
- `DW`, 32, data width of each beat and of the FIFO write data.
- `BLW`, 4, burst-length field width; a burst is `len+1` beats, maximum `2^BLW`.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `r0_req`  in  1  requester 0 burst request (level)
- `r0_len`  in  BLW  requester 0 beats minus one; stable while `r0_req` is high
- `r0_valid`  in  1  requester 0 beat valid
- `r0_data`  in  DW  requester 0 beat data
- `r0_ready`  out  1  requester 0 beat accepted when `r0_valid & r0_ready`
- `r0_done`  out  1  requester 0 last beat accepted this cycle
- `r1_req`, `r1_len`, `r1_valid`, `r1_data`, `r1_ready`, `r1_done`: same as the r0 ports, for requester 1
- `fifo_wen`  out  1  FIFO write enable (registered)
- `fifo_wdata`  out  DW  FIFO write data (registered)
- `fifo_wqfull`  in  1  FIFO almost-full; asserted while free entries ≤ 2
- `grant`  out  2  one-hot current owner; `2'b00` in IDLE
- `busy`  out  1  high in BURST

## Operation
- **States.**
  - IDLE: no owner.
  - BURST: one owner; `grant` is one-hot.
- **Reset values.**
  - State = IDLE.
  - `grant = 0`, `busy = 0`.
  - `fifo_wen = 0`, `fifo_wdata = 0`.
  - `rN_ready = 0`, `rN_done = 0`.
  - Beat counter = 0.
  - Round-robin pointer `last = 1`, so requester 0 wins first.
- **IDLE → BURST.**
  - Taken when either req is high.
  - If both are high, the winner is the requester that is not `last`. If one is high, that requester wins.
  - Load the counter with the winner's `len` and set `grant`.
- **Beat acceptance in BURST.**
  - `rN_ready = grant[N] & ~fifo_wqfull` (combinational).
  - A beat is accepted on `rN_valid & rN_ready`.
  - Each accepted beat decrements the counter.
  - Gaps on `rN_valid` are allowed; the counter holds across gaps.
- **Burst end.**
  - `rN_done = accept & (counter == 0)`, combinational in the same cycle as the last beat.
  - On that edge: state → IDLE, `last ← N`, `grant ← 0`.
- **Requester obligation.** The requester deasserts `req` by the edge that ends the burst, i.e. it registers `req` low off `done`.
- **FIFO write.**
  - `fifo_wen ← accept`.
  - `fifo_wdata ← owner data` on accept; holds otherwise.
  - Beats reach the FIFO in acceptance order; no reordering or dropping.
- **Non-owner.** The non-owner's `ready` and `done` are always 0. Its `valid` and `data` are ignored.
- **Arithmetic.**
  - Counter is BLW bits and decrements only on accept; it never underflows.
  - `len = 2^BLW - 1` gives a maximum burst of 16 beats at the default BLW.
- **Reset mid-burst.**
  - Immediate abort; all state returns to reset values.
  - A partially written burst remains in the FIFO. Recovery is the system's responsibility.

## Timing
- **Grant latency.** Req high in IDLE at cycle N → BURST and `ready` possible at cycle N+1.
- **Turnaround.** Exactly one IDLE cycle between consecutive bursts.
- **Throughput.** One beat per cycle while `~fifo_wqfull` and `valid`.
- **Write latency.** Beat accepted at cycle N → `fifo_wen` and `fifo_wdata` at cycle N+1.
- **Full handling.**
  - `fifo_wqfull` high at cycle N → no accept at cycle N.
  - At most one registered write can still be in flight; the 2-entry slack of the almost-full threshold absorbs it.
- **Release during BURST.** `req` falling while in BURST is ignored; the burst runs to `len+1` beats.
- **Simultaneous events.**
  - A new req arriving on the same edge as `done` is evaluated in the following IDLE cycle.
  - `fifo_wqfull` rising on the last beat cycle blocks that beat; `done` is deferred until the beat is accepted.

## Test plan
1. **Single burst, no contention.** After reset, r0_req=1, r0_len=3, data 0xA0..0xA3 with continuous valid → grant=01 next cycle; `fifo_wen` high for 4 consecutive cycles carrying 0xA0..0xA3; `r0_done` high with the 0xA3 accept; grant=00 on the following cycle.
2. **Contention and round-robin order.** Both req high in the same cycle, both len=1 → r0 is served first (2 beats), one IDLE cycle, then r1 (2 beats). r0 re-requests immediately and is granted only after r1 done.
3. **Back-pressure.** `fifo_wqfull` high for 3 cycles mid-burst (r1_len=7) → r1_ready=0 and no `fifo_wen` for those cycles; the counter holds; all 8 beats arrive in order and `r1_done` fires on the 8th accept.
4. **Valid gaps.** r0_len=2 with valid toggling 1,0,1,0,1 → exactly 3 FIFO writes; done on the third accept; busy high throughout.
5. **Maximum length.** r0_len=15 → 16 writes; the counter does not wrap; done on the 16th beat.
6. **Reset mid-burst.** Assert rst_n=0 after 2 of 5 beats → immediate grant=0, busy=0, fifo_wen=0. After release with both requesting, r0 wins (`last` reset to 1).
